// File: rtl/trena_rx_pkg.sv
// Shared constants for the trena receive parser: FSM state codes, ASCII limits
// and the digit test used to classify incoming bytes.
package trena_rx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DIG1   = 3'd1;
   localparam logic [2:0] ST_DIG2   = 3'd2;
   localparam logic [2:0] ST_TERM   = 3'd3;
   localparam logic [2:0] ST_FIM    = 3'd4;
   localparam logic [2:0] ST_ERRO   = 3'd5;
   localparam logic [2:0] ST_RESYNC = 3'd6;

   localparam logic [7:0] ASCII_ZERO         = 8'h30;
   localparam logic [7:0] ASCII_NOVE         = 8'h39;
   localparam logic [7:0] TERMINADOR_PADRAO  = 8'h23;

   function automatic logic eh_digito(input logic [7:0] b);
      return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
   endfunction

endpackage

// File: rtl/trena_rx_timeout.sv
// Inter-byte timeout down-counter: reloads on clear, counts while enabled and
// flags fim on the last cycle of the window.
module trena_rx_timeout #(
   parameter int unsigned CICLOS = 50000000
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic limpa_i,
   input  logic habilita_i,
   output logic fim_o
);

   localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
   localparam logic [W-1:0] CARGA = W'(CICLOS - 1);

   logic [W-1:0] cont_q, cont_d;

   always_comb begin
      cont_d = cont_q;
      if (limpa_i)
         cont_d = CARGA;
      else if (habilita_i && (cont_q != '0))
         cont_d = cont_q - 1'b1;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i)
         cont_q <= CARGA;
      else
         cont_q <= cont_d;
   end

   assign fim_o = habilita_i && !limpa_i && (cont_q == '0);

endmodule

// File: rtl/trena_rx_parser.sv
// Parses "DDD#" frames from a UART byte stream into 3 BCD digits with error
// flagging and resync. Optional inter-byte timeout under TRENA_RX_TIMEOUT_EN.
module trena_rx_parser
   import trena_rx_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = 50000000,
   parameter logic [7:0]  TERMINADOR     = TERMINADOR_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_dado,
   input  logic        rx_pronto,
   input  logic        limpa,
   output logic [11:0] medida,
   output logic        medida_valida,
   output logic        medida_ok,
   output logic        erro,
   output logic [7:0]  contagem_erros,
   output logic [2:0]  db_estado
);

   logic [2:0]  estado_q, estado_d, alvo_q, alvo_d, base;
   logic [11:0] digitos_q, digitos_d, medida_q, medida_d;
   logic [7:0]  cont_q, cont_d;
   logic        valida_q, ok_q, ok_d, erro_q;
   logic        eh_dig, eh_term, timeout, habilita;

   assign eh_dig   = eh_digito(rx_dado);
   assign eh_term  = (rx_dado == TERMINADOR);
   assign habilita = (estado_q == ST_DIG1) || (estado_q == ST_DIG2) || (estado_q == ST_TERM);

`ifdef TRENA_RX_TIMEOUT_EN
   trena_rx_timeout #(.CICLOS(TIMEOUT_CICLOS)) u_timeout (
      .clock_i    (clock),
      .reset_i    (reset),
      .limpa_i    (rx_pronto || !habilita),
      .habilita_i (habilita),
      .fim_o      (timeout)
   );
`else
   // Without the timer the parameter only exists for interface compatibility.
   assign timeout = 1'b0 & (TIMEOUT_CICLOS == 0) & habilita;
`endif

   // FIM and ERRO last one cycle; a byte arriving then is judged by the state that follows.
   always_comb begin
      base = estado_q;
      if (estado_q == ST_FIM)
         base = ST_IDLE;
      else if (estado_q == ST_ERRO)
         base = alvo_q;
      else if (estado_q > ST_RESYNC)
         base = ST_IDLE;

      estado_d  = base;
      alvo_d    = alvo_q;
      digitos_d = digitos_q;

      if (rx_pronto) begin
         case (base)
            ST_IDLE: begin
               if (eh_dig) begin
                  digitos_d = {digitos_q[7:0], rx_dado[3:0]};
                  estado_d  = ST_DIG1;
               end else if (!eh_term) begin
                  estado_d = ST_ERRO;
                  alvo_d   = ST_RESYNC;
               end
            end
            ST_DIG1, ST_DIG2: begin
               if (eh_dig) begin
                  digitos_d = {digitos_q[7:0], rx_dado[3:0]};
                  estado_d  = (base == ST_DIG1) ? ST_DIG2 : ST_TERM;
               end else begin
                  estado_d = ST_ERRO;
                  alvo_d   = eh_term ? ST_IDLE : ST_RESYNC;
               end
            end
            ST_TERM: begin
               if (eh_term) begin
                  estado_d = ST_FIM;
               end else begin
                  estado_d = ST_ERRO;
                  alvo_d   = ST_RESYNC;
               end
            end
            ST_RESYNC: begin
               if (eh_term)
                  estado_d = ST_IDLE;
            end
            default: estado_d = ST_IDLE;
         endcase
      end else if (timeout) begin
         estado_d  = ST_ERRO;
         alvo_d    = ST_IDLE;
         digitos_d = '0;
      end
   end

   // Publishing a frame takes priority over limpa; limpa takes priority over counting.
   always_comb begin
      medida_d = medida_q;
      ok_d     = ok_q;
      cont_d   = cont_q;
      if (estado_d == ST_FIM) begin
         medida_d = digitos_q;
         ok_d     = 1'b1;
      end else if (limpa) begin
         medida_d = '0;
         ok_d     = 1'b0;
      end
      if (limpa)
         cont_d = '0;
      else if ((estado_d == ST_ERRO) && (cont_q != 8'hFF))
         cont_d = cont_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= ST_IDLE;
         alvo_q    <= ST_IDLE;
         digitos_q <= '0;
         medida_q  <= '0;
         valida_q  <= 1'b0;
         ok_q      <= 1'b0;
         erro_q    <= 1'b0;
         cont_q    <= '0;
      end else begin
         estado_q  <= estado_d;
         alvo_q    <= alvo_d;
         digitos_q <= digitos_d;
         medida_q  <= medida_d;
         valida_q  <= (estado_d == ST_FIM);
         ok_q      <= ok_d;
         erro_q    <= (estado_d == ST_ERRO);
         cont_q    <= cont_d;
      end
   end

   assign medida         = medida_q;
   assign medida_valida  = valida_q;
   assign medida_ok      = ok_q;
   assign erro           = erro_q;
   assign contagem_erros = cont_q;
   assign db_estado      = estado_q;

endmodule

// File: tb/tb_trena_rx_parser.sv
// Bench for trena_rx_parser: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized byte streams.
module tb_trena_rx_parser;

   localparam int T = 100;

   logic        clock = 1'b0;
   logic        reset, rx_pronto, limpa;
   logic [7:0]  rx_dado;
   logic [11:0] medida;
   logic        medida_valida, medida_ok, erro;
   logic [7:0]  contagem_erros;
   logic [2:0]  db_estado;

   always #5 clock = ~clock;

   trena_rx_parser #(.TIMEOUT_CICLOS(T), .TERMINADOR(8'h23)) dut (
      .clock          (clock),
      .reset          (reset),
      .rx_dado        (rx_dado),
      .rx_pronto      (rx_pronto),
      .limpa          (limpa),
      .medida         (medida),
      .medida_valida  (medida_valida),
      .medida_ok      (medida_ok),
      .erro           (erro),
      .contagem_erros (contagem_erros),
      .db_estado      (db_estado)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Reference model: digits collected so far, resync flag, published values.
   int         m_n;
   bit         m_rs;
   logic [3:0] m_d [3];
   logic [11:0] m_med;
   bit         m_ok;
   int         m_cnt;
   int         m_idle;
   bit         e_val, e_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_n = 0; m_rs = 0; m_med = '0; m_ok = 0; m_cnt = 0; m_idle = 0;
      e_val = 0; e_err = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      bit dig, term;
      dig  = (b >= 8'h30) && (b <= 8'h39);
      term = (b == 8'h23);
      m_idle = 0;
      if (m_rs) begin
         if (term) m_rs = 0;
      end else if (m_n < 3) begin
         if (dig) begin
            m_d[m_n] = b[3:0];
            m_n++;
         end else if (!(m_n == 0 && term)) begin
            e_err = 1; m_n = 0; m_rs = !term;
         end
      end else begin
         if (term) begin
            e_val = 1;
            m_med = {m_d[0], m_d[1], m_d[2]};
         end else begin
            e_err = 1; m_rs = 1;
         end
         m_n = 0;
      end
   endtask

   task automatic model_edge(input bit r, input bit p, input logic [7:0] d, input bit l);
      if (r) begin
         model_reset();
         return;
      end
      e_val = 0; e_err = 0;
      if (p) model_byte(d);
`ifdef TRENA_RX_TIMEOUT_EN
      else if (m_n > 0 && !m_rs) begin
         m_idle++;
         if (m_idle == T) begin
            e_err = 1; m_n = 0; m_idle = 0;
         end
      end
`endif
      if (l) m_cnt = 0;
      else if (e_err && m_cnt < 255) m_cnt++;
      if (e_val) m_ok = 1;
      else if (l) begin
         m_med = '0; m_ok = 0;
      end
   endtask

   task automatic step();
      int st;
      @(posedge clock);
      model_edge(reset, rx_pronto, rx_dado, limpa);
      #1;
      st = e_val ? 4 : e_err ? 5 : m_rs ? 6 : m_n;
      chk("medida",         medida,         m_med);
      chk("medida_valida",  medida_valida,  e_val);
      chk("medida_ok",      medida_ok,      m_ok);
      chk("erro",           erro,           e_err);
      chk("contagem_erros", contagem_erros, m_cnt);
      chk("db_estado",      db_estado,      st);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         rx_pronto = 0; limpa = 0; rx_dado = 8'($urandom);
         step();
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_pronto = 1; rx_dado = b; limpa = 0;
      step();
      idle_cycles(gap);
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send(s[i], gap);
   endtask

   initial begin
      model_reset();
      reset = 1; rx_pronto = 0; limpa = 0; rx_dado = 8'h00;
      step(); step();
      reset = 0;
      chk("lit_reset_medida", medida, 12'h000);
      chk("lit_reset_estado", db_estado, 3'd0);

      send_str("123#", 16);
      chk("lit_frame_123", medida, 12'h123);
      chk("lit_ok_123", medida_ok, 1'b1);
      chk("lit_cnt_0", contagem_erros, 8'd0);

      send_str("4A56#789#", 16);
      chk("lit_bad_digit_cnt", contagem_erros, 8'd1);
      chk("lit_frame_789", medida, 12'h789);

      send_str("1234#", 16);
      chk("lit_wrong_term_keep", medida, 12'h789);
      chk("lit_wrong_term_cnt", contagem_erros, 8'd2);
      send_str("000#", 16);
      chk("lit_frame_000", medida, 12'h000);
      chk("lit_ok_000", medida_ok, 1'b1);

      for (int i = 0; i < 260; i++) send_str("X#", 2);
      chk("lit_saturated", contagem_erros, 8'd255);
      limpa = 1; step(); limpa = 0;
      chk("lit_clear_cnt", contagem_erros, 8'd0);
      chk("lit_clear_ok", medida_ok, 1'b0);
      chk("lit_clear_medida", medida, 12'h000);

      send_str("555#", 4);
      send_str("98", 4);
      reset = 1; rx_pronto = 0; step(); reset = 0;
      chk("lit_rst_medida", medida, 12'h000);
      chk("lit_rst_ok", medida_ok, 1'b0);
      chk("lit_rst_estado", db_estado, 3'd0);
      send_str("123#", 16);
      chk("lit_after_rst_123", medida, 12'h123);
      chk("lit_after_rst_cnt", contagem_erros, 8'd0);

`ifdef TRENA_RX_TIMEOUT_EN
      send("5", 0);
      idle_cycles(T + 4);
      chk("lit_timeout_cnt", contagem_erros, 8'd1);
      chk("lit_timeout_estado", db_estado, 3'd0);
      send_str("321#", 16);
      chk("lit_frame_321", medida, 12'h321);
`endif

      for (int k = 0; k < 2500; k++) begin
         logic [7:0] b;
         int sel, gap;
         sel = $urandom % 8;
         if (sel < 4)       b = 8'h30 + 8'($urandom % 10);
         else if (sel < 6)  b = 8'h23;
         else               b = 8'($urandom);
         rx_pronto = 1; rx_dado = b; limpa = 0;
         step();
         gap = $urandom % 5;
         for (int g = 0; g < gap; g++) begin
            rx_pronto = 0; rx_dado = 8'($urandom);
            limpa = (g > 0) && ($urandom % 20 == 0);
            reset = ($urandom % 400 == 0);
            step();
            reset = 0; limpa = 0;
         end
      end

      rx_pronto = 0; limpa = 0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
